// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Drives the coin/candy solenoids for the vending FSM, confirms
//                each drop through a synchronised drop sensor, returns a
//                one-cycle "coin paid out" pulse and flags jams by timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int PULSE_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic give_rs_05,
    input  logic give_rs_02,
    input  logic give_rs_01,
    input  logic give_candy,
    input  logic coin_sense,
    input  logic fault_clr,
    output logic coil_05,
    output logic coil_02,
    output logic coil_01,
    output logic coil_candy,
    output logic rs_05_out,
    output logic rs_02_out,
    output logic rs_01_out,
    output logic busy,
    output logic fault,
    output logic candy_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRIVE      = 3'd1,
        ST_WAIT_SENSE = 3'd2,
        ST_ACK        = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // One-hot dispense selection, bit order {candy, rs_01, rs_02, rs_05}
    localparam logic [3:0] c_SEL_05    = 4'b0001;
    localparam logic [3:0] c_SEL_02    = 4'b0010;
    localparam logic [3:0] c_SEL_01    = 4'b0100;
    localparam logic [3:0] c_SEL_CANDY = 4'b1000;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_sel;
    logic [3:0]       w_sel_nxt;
    logic             r_seen;
    logic             w_seen_nxt;
    logic             w_candy_take;
    logic             r_candy_pending;
    logic             r_candy_overrun;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    logic             w_edge;
    logic [3:0]       r_coil;
    logic [2:0]       r_rs;
    logic             r_busy;
    logic             r_fault;

    // Rising edge of the synchronised sensor
    assign w_edge = r_sync2 & ~r_sync_d;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= coin_sense;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Next-state logic; the counter measures cycles since DRIVE entry
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_seen_nxt   = r_seen;
        w_candy_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (give_rs_05) begin
                    w_sel_nxt = c_SEL_05;
                end else if (give_rs_02) begin
                    w_sel_nxt = c_SEL_02;
                end else if (give_rs_01) begin
                    w_sel_nxt = c_SEL_01;
                end else if (r_candy_pending) begin
                    w_sel_nxt    = c_SEL_CANDY;
                    w_candy_take = 1'b1;
                end
                if (give_rs_05 | give_rs_02 | give_rs_01 | r_candy_pending) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                    w_seen_nxt  = 1'b0;
                end
            end
            ST_DRIVE: begin
                // An edge during the pulse is remembered and honoured at its end
                w_seen_nxt = r_seen | w_edge;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == c_PULSE_LAST) begin
                    w_state_nxt = (r_seen | w_edge) ? ST_ACK : ST_WAIT_SENSE;
                end
            end
            ST_WAIT_SENSE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // Sensor takes precedence over a coincident timeout
                if (w_edge) begin
                    w_state_nxt = ST_ACK;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs, derived from the upcoming state so
    // each output lines up exactly with the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt           <= '0;
            r_sel           <= '0;
            r_seen          <= 1'b0;
            r_candy_pending <= 1'b0;
            r_candy_overrun <= 1'b0;
            r_coil          <= '0;
            r_rs            <= '0;
            r_busy          <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_cnt           <= w_cnt_nxt;
            r_sel           <= w_sel_nxt;
            r_seen          <= w_seen_nxt;
            r_candy_pending <= give_candy | (r_candy_pending & ~w_candy_take);
            r_candy_overrun <= r_candy_overrun | (give_candy & r_candy_pending);
            r_coil          <= (w_state_nxt == ST_DRIVE) ? w_sel_nxt : 4'b0000;
            r_rs            <= (w_state_nxt == ST_ACK) ? w_sel_nxt[2:0] : 3'b000;
            r_busy          <= (w_state_nxt != ST_IDLE);
            r_fault         <= (w_state_nxt == ST_FAULT);
        end
    end

    assign coil_05       = r_coil[0];
    assign coil_02       = r_coil[1];
    assign coil_01       = r_coil[2];
    assign coil_candy    = r_coil[3];
    assign rs_05_out     = r_rs[0];
    assign rs_02_out     = r_rs[1];
    assign rs_01_out     = r_rs[2];
    assign busy          = r_busy;
    assign fault         = r_fault;
    assign candy_overrun = r_candy_overrun;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispenser
//  Description : Self-checking bench for change_dispenser: timeline-based
//                reference model, per-cycle compare, directed scenarios and
//                randomized traffic with an automatic sensor responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int P = 8;
    localparam int T = 64;

    localparam int MD_IDLE  = 0;
    localparam int MD_JOB   = 1;
    localparam int MD_ACK   = 2;
    localparam int MD_FAULT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic give_rs_05 = 1'b0, give_rs_02 = 1'b0, give_rs_01 = 1'b0, give_candy = 1'b0;
    logic coin_sense = 1'b0, fault_clr = 1'b0;
    logic coil_05, coil_02, coil_01, coil_candy;
    logic rs_05_out, rs_02_out, rs_01_out, busy, fault, candy_overrun;
    logic [9:0] outs;

    assign outs = {candy_overrun, fault, busy, rs_01_out, rs_02_out, rs_05_out,
                   coil_candy, coil_01, coil_02, coil_05};

    change_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .give_rs_05(give_rs_05), .give_rs_02(give_rs_02), .give_rs_01(give_rs_01),
        .give_candy(give_candy), .coin_sense(coin_sense), .fault_clr(fault_clr),
        .coil_05(coil_05), .coil_02(coil_02), .coil_01(coil_01), .coil_candy(coil_candy),
        .rs_05_out(rs_05_out), .rs_02_out(rs_02_out), .rs_01_out(rs_01_out),
        .busy(busy), .fault(fault), .candy_overrun(candy_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: one job described by its start
    // cycle and the cycle of its first sensor edge ----------------
    int cyc = 0;
    int m_mode = MD_IDLE, m_kind = 0, m_start = 0, m_edge_at = -1;
    bit m_pend = 0, m_ovr = 0, m_edge = 0, m_take = 0, m_go = 0;
    bit h0 = 0, h1 = 0, h2 = 0;   // coin_sense samples of the last three edges

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = MD_IDLE; m_pend = 0; m_ovr = 0;
                h0 = 0; h1 = 0; h2 = 0; m_edge_at = -1;
            end else begin
                m_edge = h1 & ~h2;
                m_take = 0;
                case (m_mode)
                    MD_IDLE: begin
                        m_go = 1;
                        if (give_rs_05) m_kind = 0;
                        else if (give_rs_02) m_kind = 1;
                        else if (give_rs_01) m_kind = 2;
                        else if (m_pend) begin m_kind = 3; m_take = 1; end
                        else m_go = 0;
                        if (m_go) begin
                            m_mode = MD_JOB; m_start = cyc + 1; m_edge_at = -1;
                        end
                    end
                    MD_JOB: begin
                        if (m_edge && m_edge_at < 0) m_edge_at = cyc;
                        // done once the pulse is over and an edge has been seen
                        if (m_edge_at >= 0 && cyc + 1 >= m_start + P) m_mode = MD_ACK;
                        else if (cyc - m_start == T - 1) m_mode = MD_FAULT;
                    end
                    MD_ACK: m_mode = MD_IDLE;
                    default: if (fault_clr) m_mode = MD_IDLE;
                endcase
                if (give_candy && m_pend) m_ovr = 1;
                m_pend = give_candy | (m_pend & ~m_take);
                h2 = h1; h1 = h0; h0 = coin_sense;
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    logic [9:0] exp_v;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                exp_v = '0;
                if (m_mode == MD_JOB && (cyc - m_start) < P) exp_v[m_kind] = 1'b1;
                if (m_mode == MD_ACK && m_kind < 3) exp_v[4 + m_kind] = 1'b1;
                exp_v[7] = (m_mode != MD_IDLE);
                exp_v[8] = (m_mode == MD_FAULT);
                exp_v[9] = m_ovr;
                n_vec++;
                if (outs !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_compare @%0d: dut=%b model=%b", cyc, outs, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int  ncyc = 0;
    bit  auto_sense = 0, auto_rand = 0, rand_req = 0;
    int  sense_cd = -1, sense_hold = 0;
    bit  prev_coil = 0;
    int  cnt[10];
    int  first[10];
    int  base;

    task automatic step();
        bit any_coil;
        int r;
        @(negedge clk);
        ncyc++;
        give_candy = 0;
        fault_clr  = 0;
        // upstream drops a change request once it is confirmed
        if (rs_05_out) give_rs_05 = 0;
        if (rs_02_out) give_rs_02 = 0;
        if (rs_01_out) give_rs_01 = 0;
        if (sense_hold > 0) begin
            sense_hold--;
            if (sense_hold == 0) coin_sense = 0;
        end
        if (sense_cd > 0) begin
            sense_cd--;
            if (sense_cd == 0) begin coin_sense = 1; sense_hold = 2; sense_cd = -1; end
        end
        any_coil = coil_05 | coil_02 | coil_01 | coil_candy;
        if (auto_sense && any_coil && !prev_coil && sense_cd < 0) begin
            if (!auto_rand) sense_cd = 2;
            else begin
                r = int'($urandom_range(0, 19));
                if (r >= 6) sense_cd = int'($urandom_range(1, 10));
                else if (r >= 2) sense_cd = int'($urandom_range(8, 70));
            end
        end
        prev_coil = any_coil;
        if (auto_rand && sense_cd < 0 && !coin_sense && $urandom_range(0, 49) == 0) sense_cd = 1;
        if (rand_req) begin
            if (!give_rs_05) give_rs_05 = ($urandom_range(0, 29) == 0);
            else if ($urandom_range(0, 149) == 0) give_rs_05 = 0;
            if (!give_rs_02) give_rs_02 = ($urandom_range(0, 29) == 0);
            else if ($urandom_range(0, 149) == 0) give_rs_02 = 0;
            if (!give_rs_01) give_rs_01 = ($urandom_range(0, 29) == 0);
            else if ($urandom_range(0, 149) == 0) give_rs_01 = 0;
            give_candy = ($urandom_range(0, 39) == 0);
            fault_clr  = (fault && $urandom_range(0, 7) == 0) || ($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 10; i++) begin cnt[i] = 0; first[i] = -1; end
    endtask

    task automatic sample();
        for (int i = 0; i < 10; i++) begin
            if (outs[i]) begin
                cnt[i]++;
                if (first[i] < 0) first[i] = ncyc;
            end
        end
    endtask

    task automatic count_win(input int n);
        for (int i = 0; i < n; i++) begin step(); sample(); end
    endtask

    task automatic wait_hi(input int idx, input int budget, input string name);
        int k;
        k = 0;
        while (!outs[idx] && k < budget) begin step(); k++; end
        check(name, int'(outs[idx]), 1);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check({name, "_coils_drop"}, int'(outs[3:0]), 0);
        check({name, "_all_low"}, int'(outs), 0);
        step();
        step();
        rst = 0;
    endtask

    bit re_arm, re_done;

    initial begin
        #1 rst = 1;
        #1 check("reset_outputs", int'(outs), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        step();

        // single Rs5, sensor 3 cycles after coil rise
        give_rs_05 = 1;
        wait_hi(0, 5, "t1_coil_rise");
        clear_counts(); sample(); base = ncyc; sense_cd = 3;
        count_win(20);
        check("t1_coil05_len", cnt[0], 8);
        check("t1_rs05_pulses", cnt[4], 1);
        check("t1_rs05_offset", first[4] - base, 8);
        check("t1_busy_after", int'(busy), 0);

        // late sensor on Rs1
        give_rs_01 = 1;
        wait_hi(2, 5, "t2_coil_rise");
        clear_counts(); sample(); base = ncyc; sense_cd = 20;
        count_win(30);
        check("t2_coil01_len", cnt[2], 8);
        check("t2_all_coils", cnt[0] + cnt[1] + cnt[2] + cnt[3], 8);
        check("t2_rs01_offset", first[6] - base, 23);
        check("t2_rs01_pulses", cnt[6], 1);

        // jam on Rs2, then clear with request held
        give_rs_02 = 1;
        wait_hi(1, 5, "t3_coil_rise");
        clear_counts(); sample(); base = ncyc;
        count_win(70);
        check("t3_coil02_len", cnt[1], 8);
        check("t3_fault_offset", first[8] - base, 64);
        check("t3_no_rs02", cnt[5], 0);
        fault_clr = 1;
        step();
        wait_hi(1, 5, "t3_retry_rise");
        clear_counts(); sample(); sense_cd = 2;
        count_win(20);
        check("t3_retry_len", cnt[1], 8);
        check("t3_retry_rs02", cnt[5], 1);
        check("t3_retry_nofault", cnt[8], 0);

        // priority with a candy pulse mid-dispense
        auto_sense = 1;
        give_rs_02 = 1; give_rs_01 = 1;
        clear_counts();
        count_win(4);
        give_candy = 1;
        count_win(45);
        check("t4_rs02_pulses", cnt[5], 1);
        check("t4_rs01_pulses", cnt[6], 1);
        check("t4_candy_len", cnt[3], 8);
        check("t4_order", int'(first[5] >= 0 && first[5] < first[6] && first[6] < first[3]), 1);
        check("t4_no_overrun", int'(candy_overrun), 0);

        // candy overrun and back-to-back Rs2
        clear_counts();
        give_rs_02 = 1;
        step(); sample();
        step(); sample(); give_candy = 1;
        step(); sample();
        step(); sample(); give_candy = 1;
        re_arm = 0; re_done = 0;
        for (int i = 0; i < 50; i++) begin
            step(); sample();
            if (re_arm) begin give_rs_02 = 1; re_arm = 0; end
            if (rs_02_out && !re_done) begin re_arm = 1; re_done = 1; end
        end
        check("t5_rs02_pulses", cnt[5], 2);
        check("t5_coil02_len", cnt[1], 16);
        check("t5_candy_once", cnt[3], 8);
        check("t5_overrun", int'(candy_overrun), 1);

        // reset in the middle of an Rs5 pulse
        auto_sense = 0;
        give_rs_05 = 1;
        wait_hi(0, 5, "t6_coil_rise");
        step(); step();
        check("t6_coil_before_reset", int'(coil_05), 1);
        do_reset("t6");
        wait_hi(0, 6, "t6_restart");
        clear_counts(); sample(); sense_cd = 2;
        count_win(15);
        check("t6_coil_len", cnt[0], 8);
        check("t6_rs05_pulses", cnt[4], 1);

        // sensor edge on the timeout cycle wins; one cycle later it loses
        give_rs_01 = 1;
        wait_hi(2, 5, "t7a_coil_rise");
        clear_counts(); sample(); base = ncyc; sense_cd = 61;
        count_win(70);
        check("t7a_ack_offset", first[6] - base, 64);
        check("t7a_no_fault", cnt[8], 0);
        give_rs_01 = 1;
        wait_hi(2, 5, "t7b_coil_rise");
        clear_counts(); sample(); base = ncyc; sense_cd = 62;
        count_win(70);
        check("t7b_fault_offset", first[8] - base, 64);
        check("t7b_no_ack", cnt[6], 0);
        give_rs_01 = 0;
        fault_clr = 1;
        step();
        check("t7b_cleared", int'({fault, busy}), 0);

        // randomized traffic
        auto_sense = 1; auto_rand = 1; rand_req = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset("rand_reset");
            else step();
        end
        rand_req = 0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
